// File: rtl/gcd_scheduler_if.sv
// Bundle of requester, datapath-control and response signals around the
// shared GCD scheduler. The scheduler uses the slave view; the surrounding
// system (requesters, datapath, response sink) uses the master view.
interface gcd_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Requester side
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;

  // Datapath controller side
  logic                  gcd_start;
  logic [WIDTH-1:0]      gcd_din;
  logic                  gcd_clear;
  logic                  gcd_done;
  logic [WIDTH-1:0]      gcd_result;

  // Response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;

  modport slave (
    input  req, req_a, req_b, gcd_done, gcd_result, rsp_ready,
    output gnt, gcd_start, gcd_din, gcd_clear, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req, req_a, req_b, gcd_done, gcd_result, rsp_ready,
    input  gnt, gcd_start, gcd_din, gcd_clear, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin front end that shares one GCD datapath among
// NREQ requesters. Zero operands are answered without touching the datapath,
// and a watchdog aborts a job that stays in BUSY for TIMEOUT cycles.
// Every output comes straight from a flop.
module gcd_scheduler #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  gcd_scheduler_if.slave bus
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW   = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    LOAD_B,
    BUSY,
    RESP
  } state_e;

  state_e           state_q,  state_d;
  logic [ID_W-1:0]  last_q,   last_d;
  logic [ID_W-1:0]  win_q,    win_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [TW-1:0]    timer_q,  timer_d;
  logic [NREQ-1:0]  gnt_q,    gnt_d;
  logic             start_q,  start_d;
  logic [WIDTH-1:0] din_q,    din_d;
  logic             clear_q,  clear_d;
  logic             valid_q,  valid_d;
  logic [ID_W-1:0]  id_q,     id_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic             err_q,    err_d;

  // Per-requester operand views of the flat operand buses
  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  // Round-robin pick
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [ID_W-1:0]  cand;

  // Slice the flat operand buses into one word per requester
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = bus.req_a[i*WIDTH +: WIDTH];
      op_b[i] = bus.req_b[i*WIDTH +: WIDTH];
    end
  end

  // First requesting index after the last winner, wrapping modulo NREQ
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % NREQ);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    // NOTE: every variable gets a default here first so no path can leave one
    // unassigned (which would infer a latch); the three pulse outputs default
    // to 0, which is what keeps them to a single cycle.
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    a_d     = a_q;
    b_d     = b_q;
    timer_d = timer_q;
    gnt_d   = '0;
    start_d = 1'b0;
    din_d   = din_q;
    clear_d = 1'b0;
    valid_d = valid_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          win_d   = pick_idx;
          last_d  = pick_idx;
          a_d     = op_a[pick_idx];
          b_d     = op_b[pick_idx];
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        gnt_d[win_q] = 1'b1;
        if (a_q == '0 || b_q == '0) begin
          // gcd(x,0) = x and gcd(0,0) = 0, so OR gives the answer directly
          data_d  = a_q | b_q;
          err_d   = 1'b0;
          id_d    = win_q;
          state_d = RESP;
        end else begin
          start_d = 1'b1;
          din_d   = a_q;
          state_d = LOAD_B;
        end
      end

      LOAD_B: begin
        din_d   = b_q;
        timer_d = '0;
        state_d = BUSY;
      end

      BUSY: begin
        timer_d = timer_q + 1'b1;
        // done is checked first so a finish on the last allowed cycle counts
        if (bus.gcd_done) begin
          data_d  = bus.gcd_result;
          err_d   = 1'b0;
          id_d    = win_q;
          clear_d = 1'b1;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          id_d    = win_q;
          clear_d = 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        if (valid_q && bus.rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NREQ - 1);
      win_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      timer_q <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      din_q   <= '0;
      clear_q <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      a_q     <= a_d;
      b_q     <= b_d;
      timer_q <= timer_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      din_q   <= din_d;
      clear_q <= clear_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gcd_start = start_q;
  assign bus.gcd_din   = din_q;
  assign bus.gcd_clear = clear_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler. Instance 0 uses a long watchdog for
// ordinary jobs; instance 1 uses TIMEOUT=8 for the watchdog scenarios. Stimulus
// is driven on the falling edge and outputs are read on the falling edge.
// Each instance has a behavioural datapath: done rises dp_lat cycles after
// the gcd_start pulse becomes visible and drops on gcd_clear.
module tb_gcd_scheduler;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_ready;
  int                    sel;
  int                    dp_lat;

  logic [NREQ-1:0]  o_gnt   [2];
  logic             o_start [2];
  logic [WIDTH-1:0] o_din   [2];
  logic             o_clear [2];
  logic             o_valid [2];
  logic [1:0]       o_id    [2];
  logic [WIDTH-1:0] o_data  [2];
  logic             o_err   [2];

  function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x, y, t;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gcd_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    gcd_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(g == 0 ? 64 : 8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    logic             m_done;
    logic [WIDTH-1:0] m_res;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic [1:0]       m_phase;
    int               m_cnt;

    assign bus.req        = (sel == g) ? req : '0;
    assign bus.req_a      = req_a;
    assign bus.req_b      = req_b;
    assign bus.rsp_ready  = rsp_ready;
    assign bus.gcd_done   = m_done;
    assign bus.gcd_result = m_res;

    // Datapath model: A on the start cycle, B the cycle after, then count
    always @(posedge clk) begin
      if (rst) begin
        m_done  <= 1'b0;
        m_res   <= '0;
        m_a     <= '0;
        m_b     <= '0;
        m_phase <= 2'd0;
        m_cnt   <= 0;
      end else if (bus.gcd_clear) begin
        m_done  <= 1'b0;
        m_phase <= 2'd0;
      end else if (m_phase == 2'd0 && bus.gcd_start) begin
        m_a     <= bus.gcd_din;
        m_cnt   <= 2;
        m_phase <= 2'd1;
      end else if (m_phase == 2'd1) begin
        m_b     <= bus.gcd_din;
        m_cnt   <= m_cnt + 1;
        m_phase <= 2'd2;
      end else if (m_phase == 2'd2) begin
        if (m_cnt == dp_lat) begin
          m_done  <= 1'b1;
          m_res   <= gcd_ref(m_a, m_b);
          m_phase <= 2'd3;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end

    assign o_gnt[g]   = bus.gnt;
    assign o_start[g] = bus.gcd_start;
    assign o_din[g]   = bus.gcd_din;
    assign o_clear[g] = bus.gcd_clear;
    assign o_valid[g] = bus.rsp_valid;
    assign o_id[g]    = bus.rsp_id;
    assign o_data[g]  = bus.rsp_data;
    assign o_err[g]   = bus.rsp_err;
  end

  logic [NREQ-1:0]  gnt;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_din;
  logic             gcd_clear;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  assign gnt       = o_gnt[sel];
  assign gcd_start = o_start[sel];
  assign gcd_din   = o_din[sel];
  assign gcd_clear = o_clear[sel];
  assign rsp_valid = o_valid[sel];
  assign rsp_id    = o_id[sel];
  assign rsp_data  = o_data[sel];
  assign rsp_err   = o_err[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              total;
  int              passed;
  int              cyc;
  int              n_start;
  int              n_clear;
  int              n_gnt;
  int              clear_cyc;
  logic [NREQ-1:0] last_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock; requesters drop req on their grant
  task automatic step();
    @(negedge clk);
    cyc++;
    if (gcd_start === 1'b1) n_start++;
    if (gcd_clear === 1'b1) begin
      n_clear++;
      clear_cyc = cyc;
    end
    if (gnt !== '0) begin
      n_gnt++;
      last_gnt = gnt;
      req      = req & ~gnt;
    end
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget, output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < budget) begin
      step();
      lat++;
    end
    check({tag, " rsp_valid seen"}, 32'(rsp_valid), 1);
  endtask

  task automatic finish_rsp(input string tag, input int id, input int data, input logic err);
    check({tag, " rsp_id"}, 32'(rsp_id), id);
    check({tag, " rsp_data"}, 32'(rsp_data), data);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(err));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int              lat;
    int              s0;
    int              c0;
    int              g0;
    logic [NREQ-1:0] exp_g;

    total = 0; passed = 0; cyc = 0;
    n_start = 0; n_clear = 0; n_gnt = 0; clear_cyc = 0; last_gnt = '0;
    rst = 1'b1; req = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    sel = 0; dp_lat = 10;

    // Reset state
    do_reset();
    check("reset gnt", 32'(gnt), 0);
    check("reset gcd_start", 32'(gcd_start), 0);
    check("reset gcd_din", 32'(gcd_din), 0);
    check("reset gcd_clear", 32'(gcd_clear), 0);
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset rsp_id", 32'(rsp_id), 0);
    check("reset rsp_data", 32'(rsp_data), 0);
    check("reset rsp_err", 32'(rsp_err), 0);

    // 1: single job through the datapath, gcd(12,18)=6, 10 datapath cycles
    s0 = n_start; c0 = n_clear; g0 = n_gnt;
    set_op(1, 16'd12, 16'd18);
    req = 4'b0010;
    step();
    step();
    check("t1 gnt", 32'(gnt), 32'b0010);
    check("t1 gcd_start", 32'(gcd_start), 1);
    check("t1 din A", 32'(gcd_din), 12);
    step();
    check("t1 gnt pulse", 32'(gnt), 0);
    check("t1 start pulse", 32'(gcd_start), 0);
    check("t1 din B", 32'(gcd_din), 18);
    wait_valid("t1", 40, lat);
    check("t1 latency", lat + 3, 14);
    finish_rsp("t1", 1, 6, 1'b0);
    check("t1 start count", n_start - s0, 1);
    check("t1 clear count", n_clear - c0, 1);
    check("t1 gnt count", n_gnt - g0, 1);

    // 2a: requesters 0 and 2 both waiting, 0 wins first after reset
    do_reset();
    dp_lat = 3;
    set_op(0, 16'd8, 16'd12);
    set_op(2, 16'd8, 16'd12);
    req = 4'b0101;
    wait_valid("t2a first", 30, lat);
    finish_rsp("t2a first", 0, 4, 1'b0);
    req = req | 4'b0001;
    wait_valid("t2a second", 30, lat);
    finish_rsp("t2a second", 2, 4, 1'b0);

    // 2b: all four waiting, order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(6 * (i + 1)), 16'(4 * (i + 1)));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_valid("t2b", 30, lat);
      exp_g = '0;
      exp_g[k % NREQ] = 1'b1;
      check("t2b grant order", 32'(last_gnt), 32'(exp_g));
      finish_rsp("t2b", k % NREQ, 2 * ((k % NREQ) + 1), 1'b0);
      req = (k < 4) ? 4'b1111 : 4'b0000;
    end

    // 3: zero-operand bypass, 3-cycle latency, datapath untouched
    s0 = n_start;
    set_op(3, 16'd0, 16'd9);
    req = 4'b1000;
    step();
    step();
    check("t3 gnt", 32'(gnt), 32'b1000);
    step();
    check("t3 valid at 3", 32'(rsp_valid), 1);
    finish_rsp("t3 0,9", 3, 9, 1'b0);
    set_op(3, 16'd0, 16'd0);
    req = 4'b1000;
    wait_valid("t3 0,0", 10, lat);
    check("t3 0,0 latency", lat, 3);
    finish_rsp("t3 0,0", 3, 0, 1'b0);
    set_op(3, 16'd5, 16'd0);
    req = 4'b1000;
    wait_valid("t3 5,0", 10, lat);
    finish_rsp("t3 5,0", 3, 5, 1'b0);
    check("t3 no gcd_start", n_start - s0, 0);

    // 5: response back-pressure while other requests arrive
    dp_lat = 3;
    set_op(1, 16'd9, 16'd6);
    set_op(0, 16'd10, 16'd15);
    set_op(2, 16'd14, 16'd21);
    req = 4'b0010;
    wait_valid("t5 held", 30, lat);
    req = req | 4'b0101;
    g0 = n_gnt;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t5 hold valid", 32'(rsp_valid), 1);
      check("t5 hold id", 32'(rsp_id), 1);
      check("t5 hold data", 32'(rsp_data), 3);
      check("t5 hold err", 32'(rsp_err), 0);
    end
    check("t5 no gnt while held", n_gnt - g0, 0);
    finish_rsp("t5 held", 1, 3, 1'b0);
    wait_valid("t5 next", 30, lat);
    finish_rsp("t5 next", 2, 7, 1'b0);
    wait_valid("t5 last", 30, lat);
    finish_rsp("t5 last", 0, 5, 1'b0);

    // 6: reset while BUSY drops the job, then a fresh job works
    dp_lat = 10000;
    set_op(1, 16'd35, 16'd21);
    req = 4'b0010;
    for (int k = 0; k < 6; k++) step();
    rst = 1'b1;
    step();
    check("t6 gnt", 32'(gnt), 0);
    check("t6 gcd_start", 32'(gcd_start), 0);
    check("t6 gcd_din", 32'(gcd_din), 0);
    check("t6 gcd_clear", 32'(gcd_clear), 0);
    check("t6 rsp_valid", 32'(rsp_valid), 0);
    check("t6 rsp_id", 32'(rsp_id), 0);
    check("t6 rsp_data", 32'(rsp_data), 0);
    check("t6 rsp_err", 32'(rsp_err), 0);
    rst = 1'b0;
    req = '0;
    c0 = n_clear;
    for (int k = 0; k < 10; k++) step();
    check("t6 no response after reset", 32'(rsp_valid), 0);
    check("t6 no clear after reset", n_clear - c0, 0);
    dp_lat = 3;
    set_op(2, 16'd21, 16'd14);
    req = 4'b0100;
    wait_valid("t6 fresh", 30, lat);
    finish_rsp("t6 fresh", 2, 7, 1'b0);

    // 4: watchdog on the TIMEOUT=8 instance
    do_reset();
    sel = 1;
    dp_lat = 10000;
    set_op(1, 16'd12, 16'd18);
    c0 = n_clear;
    req = 4'b0010;
    wait_valid("t4 hang", 40, lat);
    check("t4 hang latency", lat, 12);
    check("t4 clear before valid", clear_cyc, cyc - 1);
    check("t4 clear count", n_clear - c0, 1);
    finish_rsp("t4 hang", 1, 0, 1'b1);

    dp_lat = 8;
    req = 4'b0010;
    wait_valid("t4 done at limit", 40, lat);
    check("t4 done at limit latency", lat, 12);
    finish_rsp("t4 done at limit", 1, 6, 1'b0);

    dp_lat = 7;
    req = 4'b0010;
    wait_valid("t4 done before limit", 40, lat);
    check("t4 done before limit latency", lat, 11);
    finish_rsp("t4 done before limit", 1, 6, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
